// File: rtl/dbus_xbar_n.sv
// Single-master, N-slave data-bus crossbar: base/mask decode, one-hot slave select, error response.
// Optional hung-slave watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_xbar_n #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h0C00_0000, 32'h0200_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_bstart,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic                       m_ttype,
    input  logic [1:0]                 m_tsize,
    input  logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_bdone,
    output logic                       m_berr,
    output logic                       m_busy,
    output logic [N_SLAVES-1:0]        s_ss,
    output logic [ADDR_W-1:0]          s_addr,
    output logic                       s_ttype,
    output logic [1:0]                 s_tsize,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_bdone,
    output logic [ADDR_W-1:0]          err_addr
);
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic             hit;
    logic [SEL_W-1:0] hit_idx;
    logic             aligned;
    logic             sel_bdone;
    logic [DATA_W-1:0] sel_rdata;
    logic             done_ok;
    logic             tmo;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        aligned = 1'b1;
        if (m_tsize == 2'd1)
            aligned = ~m_addr[0];
        else if (m_tsize[1])
            aligned = (m_addr[1:0] == 2'b00);
    end

    assign sel_bdone = s_bdone[sel];
    assign sel_rdata = s_rdata[sel*DATA_W +: DATA_W];
    assign done_ok   = (state == ACTIVE) && sel_bdone;

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    // The limit fires in the TIMEOUT_CYCLES-th active cycle; a same-cycle s_bdone still wins.
    assign tmo = (state == ACTIVE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    assign m_busy  = (state != IDLE);
    assign m_bdone = done_ok || tmo || (state == ERR);
    assign m_berr  = (state == ERR) || (tmo && !sel_bdone);
    assign m_rdata = (done_ok && !s_ttype) ? sel_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            s_ss     <= '0;
            s_addr   <= '0;
            s_ttype  <= 1'b0;
            s_tsize  <= 2'd0;
            s_wdata  <= '0;
            err_addr <= '0;
`ifdef DBUS_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m_bstart) begin
                        s_addr  <= m_addr;
                        s_ttype <= m_ttype;
                        s_tsize <= m_tsize;
                        s_wdata <= m_wdata;
                        if (hit && aligned) begin
                            sel   <= hit_idx;
                            s_ss  <= N_SLAVES'(1) << hit_idx;
                            state <= ACTIVE;
`ifdef DBUS_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (sel_bdone || tmo) begin
                        s_ss  <= '0;
                        state <= IDLE;
                        if (!sel_bdone)
                            err_addr <= s_addr;
                    end
`ifdef DBUS_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ERR: begin
                    err_addr <= s_addr;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_xbar_n.sv
// Self-checking bench for dbus_xbar_n: directed map cases, random traffic against a
// reference decoder, back-to-back issue, ignored mid-flight requests and mid-transaction reset.
module tb_dbus_xbar_n;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         m_bstart;
    logic [31:0]  m_addr;
    logic         m_ttype;
    logic [1:0]   m_tsize;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_bdone, m_berr, m_busy;
    logic [3:0]   s_ss;
    logic [31:0]  s_addr;
    logic         s_ttype;
    logic [1:0]   s_tsize;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_bdone;
    logic [31:0]  err_addr;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_err = '0;
    logic [31:0] base_t [4] = '{32'h0000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0C00_0000};
    logic [31:0] mask_t [4] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFF00_0000};

    always #5 clk = ~clk;

    dbus_xbar_n #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .m_bstart(m_bstart), .m_addr(m_addr), .m_ttype(m_ttype),
        .m_tsize(m_tsize), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_bdone(m_bdone),
        .m_berr(m_berr), .m_busy(m_busy), .s_ss(s_ss), .s_addr(s_addr), .s_ttype(s_ttype),
        .s_tsize(s_tsize), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
        .err_addr(err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: misaligned or unmapped gives -1, else first matching table entry.
    function automatic int ref_sel(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd1 && a[0]) return -1;
        if (sz == 2'd2 && a[1:0] != 2'b00) return -1;
        for (int i = 0; i < 4; i++)
            if ((a & mask_t[i]) == base_t[i]) return i;
        return -1;
    endfunction

    // Issue one transaction starting now (just after a rising edge, DUT idle).
    // lat = number of ACTIVE cycles, the last one carrying the slave's s_bdone.
    task automatic txn(input logic [31:0] a, input logic tt, input logic [1:0] sz,
                       input logic [31:0] wd, input int lat, input bit poke);
        int s;
        logic [31:0] exp_rd;
        s = ref_sel(a, sz);
        m_bstart = 1'b1; m_addr = a; m_ttype = tt; m_tsize = sz; m_wdata = wd;
        @(posedge clk); #1;
        m_bstart = 1'b0; m_addr = $urandom; m_ttype = ~tt; m_tsize = 2'($urandom); m_wdata = $urandom;
        if (s < 0) begin
            #1;
            chk("err_bdone", 64'(m_bdone), 64'd1);
            chk("err_berr", 64'(m_berr), 64'd1);
            chk("err_ss", 64'(s_ss), 64'd0);
            chk("err_rdata", 64'(m_rdata), 64'd0);
            chk("err_busy", 64'(m_busy), 64'd1);
            @(posedge clk); #1;
            exp_err = a;
            chk("err_addr", 64'(err_addr), 64'(exp_err));
            chk("err_after_bdone", 64'(m_bdone), 64'd0);
            chk("err_after_busy", 64'(m_busy), 64'd0);
        end else begin
            for (int i = 0; i < lat; i++) begin
                s_bdone = 4'($urandom) & ~(4'b0001 << s);
                s_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (poke && i == 0 && lat > 1) begin
                    m_bstart = 1'b1; m_addr = 32'h3000_0000;
                end
                if (i == lat - 1) s_bdone[s] = 1'b1;
                exp_rd = s_rdata[s*32 +: 32];
                #1;
                chk("act_ss", 64'(s_ss), 64'(4'b0001 << s));
                chk("act_saddr", 64'(s_addr), 64'(a));
                chk("act_sttype", 64'(s_ttype), 64'(tt));
                chk("act_stsize", 64'(s_tsize), 64'(sz));
                chk("act_swdata", 64'(s_wdata), 64'(wd));
                chk("act_bdone", 64'(m_bdone), 64'(i == lat - 1));
                chk("act_berr", 64'(m_berr), 64'd0);
                chk("act_rdata", 64'(m_rdata), (i == lat - 1 && !tt) ? 64'(exp_rd) : 64'd0);
                chk("act_erraddr", 64'(err_addr), 64'(exp_err));
                @(posedge clk); #1;
                m_bstart = 1'b0;
            end
            s_bdone = '0;
            #1;
            chk("done_ss", 64'(s_ss), 64'd0);
            chk("done_busy", 64'(m_busy), 64'd0);
            chk("done_bdone", 64'(m_bdone), 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return {16'h0000, 16'($urandom)};
            1: return {24'h1000_00, 8'($urandom)};
            2: return {16'h0200, 16'($urandom)};
            3: return {8'h0C, 24'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; m_bstart = 1'b0; m_addr = '0; m_ttype = 1'b0; m_tsize = 2'd0;
        m_wdata = '0; s_rdata = '0; s_bdone = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", 64'(s_ss), 64'd0);
        chk("rst_bdone", 64'(m_bdone), 64'd0);
        chk("rst_berr", 64'(m_berr), 64'd0);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_rdata", 64'(m_rdata), 64'd0);
        chk("rst_saddr", 64'(s_addr), 64'd0);
        chk("rst_erraddr", 64'(err_addr), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed map cases.
        s_rdata = '0;
        txn(32'h0000_0010, 1'b0, 2'd2, 32'h0, 3, 1'b0);
        txn(32'h1000_0004, 1'b1, 2'd0, 32'h0000_00A5, 2, 1'b0);
        txn(32'h3000_0000, 1'b0, 2'd2, 32'h0, 1, 1'b0);
        txn(32'h0000_0002, 1'b0, 2'd2, 32'h0, 1, 1'b0);
        txn(32'h0200_0001, 1'b0, 2'd1, 32'h0, 1, 1'b0);
        txn(32'h0C12_3456, 1'b1, 2'd1, 32'h1234_5678, 1, 1'b1);

`ifdef DBUS_TIMEOUT_EN
        // Slave 2 never answers: watchdog fires in the 8th active cycle.
        m_bstart = 1'b1; m_addr = 32'h0200_0000; m_ttype = 1'b0; m_tsize = 2'd2;
        @(posedge clk); #1;
        m_bstart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tmo_ss", 64'(s_ss), 64'd4);
            chk("tmo_bdone", 64'(m_bdone), 64'(i == 7));
            chk("tmo_berr", 64'(m_berr), 64'(i == 7));
            @(posedge clk); #1;
        end
        exp_err = 32'h0200_0000;
        chk("tmo_ss_drop", 64'(s_ss), 64'd0);
        chk("tmo_erraddr", 64'(err_addr), 64'(exp_err));
        txn(32'h0200_0004, 1'b0, 2'd2, 32'h0, 8, 1'b0);
`else
        // Without the watchdog a slow slave is simply waited on.
        txn(32'h0200_0000, 1'b0, 2'd2, 32'h0, 20, 1'b1);
`endif

        // Random back-to-back traffic.
        for (int n = 0; n < 60; n++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 2));
            txn(rand_addr(), 1'($urandom), sz, $urandom, $urandom_range(1, 6), 1'($urandom));
        end

        // Reset in the middle of an active access, with the slave answering that cycle.
        m_bstart = 1'b1; m_addr = 32'h0000_0040; m_ttype = 1'b0; m_tsize = 2'd2;
        @(posedge clk); #1;
        m_bstart = 1'b0;
        s_bdone = 4'b0001; s_rdata = {4{32'hCAFE_F00D}};
        rst_n = 1'b0;
        #1;
        exp_err = '0;
        chk("mid_rst_ss", 64'(s_ss), 64'd0);
        chk("mid_rst_busy", 64'(m_busy), 64'd0);
        chk("mid_rst_bdone", 64'(m_bdone), 64'd0);
        chk("mid_rst_erraddr", 64'(err_addr), 64'd0);
        s_bdone = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(32'h0000_0020, 1'b0, 2'd2, 32'h0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
